// File: rtl/holder_pkg.sv
// Shared types and constants for the weighted pulse holder.
package holder_pkg;

   typedef enum logic [1:0] {StIdle, StHold, StWaitRel} state_e;

   localparam int unsigned W_SEL0 = 88;
   localparam int unsigned W_SEL1 = 80;
   localparam int unsigned W_SEL2 = 56;
   localparam int unsigned W_SEL3 = 32;

   // Adds a and b, clamping the result to 2^w-1.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      logic [32:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV sysclk cycles (TICK_DIV=1 ticks every cycle).
module tick_gen #(
   parameter int unsigned TICK_DIV = 5207
) (
   input  logic sysclk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;

   assign tick = (pre_q == LAST);

   always_comb begin
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_d;
   end

endmodule

// File: rtl/weighted_pulse_holder.sv
// Holds out high for a weighted number of prescaled ticks per trigger.
// Optional HOLDER_EXTEND_EN: a fresh trigger edge during a hold extends it.
module weighted_pulse_holder
   import holder_pkg::*;
#(
   parameter int unsigned N_SEL = 4,
   parameter int unsigned CNT_W = 9,
   parameter logic [N_SEL*CNT_W-1:0] WEIGHTS = {9'(W_SEL3), 9'(W_SEL2), 9'(W_SEL1), 9'(W_SEL0)},
   parameter int unsigned TICK_DIV = 5207
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [N_SEL-1:0] sel,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] total_o
);

   localparam int unsigned SUM_W = CNT_W + $clog2(N_SEL);

   logic             tick;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic             done_q, done_d;
   logic [SUM_W-1:0] sum_raw;
   logic [CNT_W-1:0] sum_sat;
   logic [CNT_W:0]   count_inc;
   logic             ext;

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_comb begin
      sum_raw = '0;
      for (int unsigned i = 0; i < N_SEL; i++) begin
         if (sel[i]) sum_raw = sum_raw + SUM_W'(WEIGHTS[i*CNT_W +: CNT_W]);
      end
      sum_sat = CNT_W'(sat_add(32'(sum_raw), 32'd0, CNT_W));
   end

   assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

`ifdef HOLDER_EXTEND_EN
   logic trig_q, trig_d;

   assign trig_d = tick ? trig : trig_q;
   assign ext    = trig && !trig_q && (sel != '0);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) trig_q <= 1'b0;
      else        trig_q <= trig_d;
   end
`else
   assign ext = 1'b0;
`endif

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         total_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         total_q <= total_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      total_d = total_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (tick && trig && (sel != '0) && (sum_sat != '0)) begin
               total_d = sum_sat;
               count_d = '0;
               state_d = StHold;
            end
         end
         StHold: begin
            if (tick) begin
               // An extension on the completion tick keeps the hold alive.
               if (ext) begin
                  total_d = CNT_W'(sat_add(32'(total_q), 32'(sum_sat), CNT_W));
                  count_d = count_inc[CNT_W-1:0];
               end else if (count_inc >= {1'b0, total_q}) begin
                  count_d = '0;
                  done_d  = 1'b1;
                  state_d = StWaitRel;
               end else begin
                  count_d = count_inc[CNT_W-1:0];
               end
            end
         end
         StWaitRel: begin
            if (tick && !trig) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out     = (state_q == StHold);
      busy    = (state_q != StIdle);
      done    = done_q;
      total_o = total_q;
   end

endmodule

// File: tb/tb_weighted_pulse_holder.sv
// Self-checking bench for weighted_pulse_holder: vector table, corner sequences, random vs model.
module tb_weighted_pulse_holder;

   localparam int unsigned TD = 4;
`ifdef HOLDER_EXTEND_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trig = 1'b0;
   logic [3:0] sel = 4'd0;
   logic       out, busy, done;
   logic [8:0] tot1;
   logic       trig2 = 1'b0;
   logic [3:0] sel2 = 4'd0;
   logic       out2, busy2, done2;
   logic [7:0] tot2;

   int total_cnt = 0;
   int bad = 0;

   always #5 clk = ~clk;

   weighted_pulse_holder #(
      .N_SEL   (4),
      .CNT_W   (9),
      .WEIGHTS ({9'd32, 9'd56, 9'd80, 9'd88}),
      .TICK_DIV(TD)
   ) dut (
      .sysclk (clk),
      .rst_n  (rst_n),
      .trig   (trig),
      .sel    (sel),
      .out    (out),
      .busy   (busy),
      .done   (done),
      .total_o(tot1)
   );

   weighted_pulse_holder #(
      .N_SEL   (4),
      .CNT_W   (8),
      .WEIGHTS ({8'd32, 8'd56, 8'd80, 8'd88}),
      .TICK_DIV(1)
   ) dut2 (
      .sysclk (clk),
      .rst_n  (rst_n),
      .trig   (trig2),
      .sel    (sel2),
      .out    (out2),
      .busy   (busy2),
      .done   (done2),
      .total_o(tot2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic cur_out(input int which);
      return (which != 0) ? out2 : out;
   endfunction

   function automatic logic cur_done(input int which);
      return (which != 0) ? done2 : done;
   endfunction

   function automatic int ref_sum(input logic [3:0] s, input int maxv);
      int w[4];
      int acc;
      w = '{88, 80, 56, 32};
      acc = 0;
      for (int i = 0; i < 4; i++) if (s[i]) acc += w[i];
      return (acc > maxv) ? maxv : acc;
   endfunction

   // Waits for out to rise, then counts sysclk samples with out high and done pulses seen.
   task automatic measure(input int which, input int bound, output int len, output int ndone);
      int k;
      len = 0;
      ndone = 0;
      k = 0;
      while (cur_out(which) == 1'b0 && k < bound) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (cur_out(which) == 1'b0) begin
         len = -1;
         return;
      end
      while (cur_out(which) && len < bound) begin
         len++;
         if (cur_done(which)) ndone++;
         @(posedge clk);
         #1;
      end
      if (cur_done(which)) ndone++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] sel;
      int         exp_total;
   } vec_t;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      vec_t vecs[7];
      int   len, nd, acc, seen_bad, exp_len;
      int   mode, rem, mtotal, s, nt;
      logic mtrig_q, mdone, mext, tck;
      logic [11:0] exp_v, act_v;

      vecs[0] = '{4'b0001, 88};
      vecs[1] = '{4'b0010, 80};
      vecs[2] = '{4'b0100, 56};
      vecs[3] = '{4'b1000, 32};
      vecs[4] = '{4'b0011, 168};
      vecs[5] = '{4'b0101, 144};
      vecs[6] = '{4'b1111, 256};

      rst_n = 1'b0;
      cyc(2);
      check("reset_out_busy_done", {29'd0, out, busy, done}, 32'd0);
      check("reset_total", 32'(tot1), 32'd0);
      rst_n = 1'b1;

      // Weight table: hold length, single done, busy until release.
      for (int v = 0; v < 7; v++) begin
         sel  = vecs[v].sel;
         trig = 1'b1;
         measure(0, 2000, len, nd);
         check($sformatf("vec%0d_len", v), 32'(len), 32'(vecs[v].exp_total * TD));
         check($sformatf("vec%0d_done", v), 32'(nd), 32'd1);
         check($sformatf("vec%0d_total", v), 32'(tot1), 32'(vecs[v].exp_total));
         cyc(3 * TD);
         check($sformatf("vec%0d_busy_held", v), {31'd0, busy}, 32'd1);
         trig = 1'b0;
         cyc(2 * TD);
         check($sformatf("vec%0d_released", v), {30'd0, busy, out}, 32'd0);
      end

      // No selectors: nothing starts, total keeps the last value.
      sel  = 4'b0000;
      trig = 1'b1;
      acc  = 0;
      for (int i = 0; i < 50 * TD; i++) begin
         @(posedge clk);
         #1;
         if (out || busy || done) acc++;
      end
      check("sel0_idle", 32'(acc), 32'd0);
      check("sel0_total_kept", 32'(tot1), 32'd256);
      trig = 1'b0;
      cyc(2 * TD);

      // Asynchronous reset mid-hold, then a fresh hold with trig still high.
      sel  = 4'b0010;
      trig = 1'b1;
      acc  = 0;
      while (!out && acc < 100) begin
         cyc(1);
         acc++;
      end
      cyc(30 * TD);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {22'd0, out, busy, tot1}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(TD - 1);
      check("post_reset_no_early_start", {31'd0, out}, 32'd0);
      cyc(1);
      check("post_reset_first_tick", {31'd0, out}, 32'd1);
      measure(0, 2000, len, nd);
      check("post_reset_len", 32'(len), 32'(80 * TD));
      check("post_reset_total", 32'(tot1), 32'd80);
      trig = 1'b0;
      cyc(2 * TD);

      // Retrigger edge during hold: extends only with the feature compiled in.
      sel  = 4'b0100;
      trig = 1'b1;
      acc  = 0;
      while (!out && acc < 100) begin
         cyc(1);
         acc++;
      end
      len = 0;
      while (out && len < 2000) begin
         len++;
         if (len == 18 * TD) trig = 1'b0;
         if (len == 20 * TD) begin
            trig = 1'b1;
            sel  = 4'b1000;
         end
         cyc(1);
      end
      exp_len = EXT_EN ? 88 : 56;
      check("extend_len", 32'(len), 32'(exp_len * TD));
      check("extend_total", 32'(tot1), 32'(exp_len));
      trig = 1'b0;
      cyc(2 * TD);

      // Second instance: 8-bit saturation and back-to-back retrigger at TICK_DIV=1.
      sel2  = 4'b1111;
      trig2 = 1'b1;
      measure(1, 2000, len, nd);
      check("sat8_len", 32'(len), 32'd255);
      check("sat8_total", 32'(tot2), 32'd255);
      check("sat8_done", 32'(nd), 32'd1);
      cyc(3);
      check("b2b_wait_rel", {30'd0, busy2, out2}, 32'd2);
      trig2 = 1'b0;
      cyc(1);
      check("b2b_rearmed", {31'd0, busy2}, 32'd0);
      trig2 = 1'b1;
      sel2  = 4'b0001;
      cyc(1);
      check("b2b_restart", {31'd0, out2}, 32'd1);
      measure(1, 2000, len, nd);
      check("b2b_len", 32'(len), 32'd88);
      check("b2b_total", 32'(tot2), 32'd88);
      trig2 = 1'b0;

      // Random stimulus against a tick-level model tracking remaining hold ticks.
      trig = 1'b0;
      sel  = 4'b0000;
      do_reset();
      mode = 0; rem = 0; mtotal = 0; mtrig_q = 1'b0;
      seen_bad = bad;
      for (int e = 0; e < 20000; e++) begin
         @(posedge clk);
         tck   = ((e % TD) == TD - 1);
         mdone = 1'b0;
         if (tck) begin
            s = ref_sum(sel, 511);
            case (mode)
               0: if (trig && s != 0) begin
                  mtotal = s;
                  rem    = s;
                  mode   = 1;
               end
               1: begin
                  mext = EXT_EN && trig && !mtrig_q && (sel != 4'd0);
                  if (mext) begin
                     nt     = (mtotal + s > 511) ? 511 : mtotal + s;
                     rem    = rem - 1 + (nt - mtotal);
                     if (rem < 1) rem = 1;
                     mtotal = nt;
                  end else begin
                     rem--;
                     if (rem == 0) begin
                        mode  = 2;
                        mdone = 1'b1;
                     end
                  end
               end
               default: if (!trig) mode = 0;
            endcase
            mtrig_q = trig;
         end
         #1;
         exp_v = {(mode == 1), (mode != 0), mdone, 9'(mtotal)};
         act_v = {out, busy, done, tot1};
         check($sformatf("random_e%0d", e), 32'(act_v), 32'(exp_v));
         if (bad - seen_bad >= 10) break;
         if ($urandom_range(0, 39) == 0) trig = ~trig;
         if ($urandom_range(0, 59) == 0) sel = 4'($urandom_range(0, 15));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad);
      $finish;
   end

endmodule
